muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative multiply/divide unit with its own sequencer and the architectural HI/LO registers, sitting beside the ALU in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decoded instruction stream and runs multiply and divide over multiple cycles. It stalls the pipeline when a later instruction needs HI/LO or the unit while an operation is in flight. It supports flush of an in-flight operation on a branch/jump squash.

## Interface
- No parameters. Iteration count is fixed at 32.
- clk  in  1  pipeline clock. All state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  EX holds a valid HI/LO-class instruction this cycle.
- op  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are ignored (no-op).
- rs_data  in  32  forwarded rs operand (multiplicand/dividend; MTHI/MTLO source).
- rt_data  in  32  forwarded rt operand (multiplier/divisor).
- mf_req  in  1  EX holds MFHI/MFLO this cycle.
- flush  in  1  squash any in-flight operation.
- busy  out  1  multi-cycle operation in progress.
- stall  out  1  hold IF/ID/EX; combinational.
- done  out  1  one-cycle pulse when HI/LO commit a multiply/divide result.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

## Operation
- Reset values: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0. Internal accumulators are cleared.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start with op 000–011 and flush=0: latch magnitudes of the operands (signed ops only; unsigned ops use raw values), latch the result sign flags and the op; counter←0; go to CALC.
  - start with op 100/101: write rs_data into hi/lo at the edge; stay in IDLE.
- CALC: one iteration per cycle; counter increments; after the iteration where counter==31, go to FIX.
  - Multiply: shift-add over a 64-bit product.
  - Divide: restoring, one quotient bit per cycle, with a 33-bit partial remainder.
- FIX:
  - Apply the sign. Product is negated (64-bit two's complement) when the operand signs differ. Quotient is negated when the signs differ. Remainder takes the dividend's sign.
  - Write hi/lo, pulse done, and return to IDLE.
- Divide by zero (divisor 0), both DIV and DIVU: lo=FFFFFFFF, hi=rs_data as presented at start. Still takes the full latency.
- DIV 80000000 / FFFFFFFF: lo=80000000, hi=00000000. This is the natural magnitude result; no trap.
- busy = state is CALC or FIX.
- stall = busy && (mf_req || start). Any start seen while busy is ignored; the stall makes the pipeline re-present it.
- flush in CALC/FIX: go to IDLE at the next edge. hi/lo are unchanged and done is not pulsed.
- flush together with start in IDLE: flush wins and start is ignored.
- hi/lo are read directly by MFHI/MFLO forwarding when not busy.

## Timing
- Multiply/divide start sampled at edge T:
  - CALC occupies cycles T+1..T+32; FIX is cycle T+33.
  - done=1 during T+33.
  - New hi/lo are visible from T+34.
  - busy=1 during T+1..T+33.
- MTHI/MTLO at edge T: new value visible from T+1; busy is never set.
- Back-to-back: a start presented in T+34 (IDLE) is accepted.
- stall is combinational from mf_req/start/busy with no register delay. It deasserts in T+34, the same cycle hi/lo become valid.
- Reset asserted mid-operation: the block returns immediately to IDLE with hi=lo=0. No done pulse.

## Test plan
- MULT rs=FFFFFFFD (−3), rt=00000007 at T: busy in T+1..T+33, done in T+33; hi=FFFFFFFF, lo=FFFFFFEB at T+34.
- MULTU rs=rt=FFFFFFFF: hi=FFFFFFFE, lo=00000001. Then DIV rs=FFFFFFF9 (−7), rt=00000002 at T+34: lo=FFFFFFFD, hi=FFFFFFFF after 34 cycles.
- DIVU rs=00001234, rt=0: lo=FFFFFFFF, hi=00001234 at T+34. DIV rs=80000000, rt=FFFFFFFF: lo=80000000, hi=0.
- mf_req held high from T+5 during MULT: stall=1 through T+33 and 0 at T+34, where hi/lo already hold the product. A start with op=MTLO during busy is also stalled and then applied in T+34.
- flush at T+10 of a DIV with prior hi=11111111, lo=22222222: IDLE at T+11, busy=0, no done, hi/lo unchanged. flush+start in IDLE: no state change.
- reset pulsed at T+20 of a MULTU: hi=lo=0, busy=0, and done never pulses. A subsequent MTHI rs=CAFEBABE makes hi=CAFEBABE the next cycle.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer with architectural HI/LO registers.
// Operations take 32 CALC cycles plus one FIX cycle; MTHI/MTLO write in one cycle.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mf_req,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_muldiv;
    logic        w_signed;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_madd;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_prod_s;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;

    always_comb begin
        w_muldiv = ~op[2];
        w_signed = ~op[0];
        w_sa     = w_signed & rs_data[31];
        w_sb     = w_signed & rt_data[31];
        w_a_mag  = w_sa ? -rs_data : rs_data;
        w_b_mag  = w_sb ? -rt_data : rt_data;

        // Shift-add step: add multiplicand into the upper half, then shift right.
        w_madd   = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_a} : 33'd0);

        // Restoring step on a 33-bit partial remainder; the difference fits in 32 bits.
        w_shift  = {r_rem, r_quo[31]};
        w_ge     = (w_shift >= {1'b0, r_b});
        w_sub    = w_shift[31:0] - r_b;

        w_prod_s = r_neg_q ? -r_prod : r_prod;
        // Divide by zero leaves remainder == |dividend|, so its signed form is rs itself.
        w_quo_s  = (r_b == '0) ? '1 : (r_neg_q ? -r_quo : r_quo);
        w_rem_s  = r_neg_r ? -r_rem : r_rem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (w_muldiv) begin
                            r_a      <= w_a_mag;
                            r_b      <= w_b_mag;
                            r_prod   <= {32'h0, w_b_mag};
                            r_rem    <= '0;
                            r_quo    <= w_a_mag;
                            r_is_div <= op[1];
                            r_neg_q  <= w_sa ^ w_sb;
                            r_neg_r  <= w_sa;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_CALC;
                        end else if (op[1:0] == 2'b00) begin
                            r_hi <= rs_data;
                        end else if (op[1:0] == 2'b01) begin
                            r_lo <= rs_data;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_rem <= w_ge ? w_sub : w_shift[31:0];
                            r_quo <= {r_quo[30:0], w_ge};
                        end else begin
                            r_prod <= {w_madd, r_prod[31:1]};
                        end
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_s;
                            r_lo <= w_quo_s;
                        end else begin
                            r_hi <= w_prod_s[63:32];
                            r_lo <= w_prod_s[31:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign stall = r_busy && (mf_req || start);
    // A flush during FIX cancels the commit, so the pulse is suppressed with it.
    assign done  = r_done && !flush;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized operations
// compared against an arithmetic reference model of HI/LO.
module tb_muldiv_ctrl;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mf_req;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mf_req  (mf_req),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] ref_model(input logic [2:0] f_op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        case (f_op)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            OP_MULTU: begin
                up = {32'h0, a} * {32'h0, b};
                return up;
            end
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge of cycle T+34.
    task automatic muldiv(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        exp     = ref_model(o, a, b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        for (int k = 1; k <= 33; k++) begin
            check($sformatf("busy_c%0d", k), busy, 1'b1);
            check($sformatf("done_c%0d", k), done, (k == 33) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        check("end_busy", busy, 1'b0);
        check("end_done", done, 1'b0);
        check($sformatf("hilo_op%0d_%h_%h", o, a, b), {hi, lo}, {m_hi, m_lo});
    endtask

    // Single-cycle op (MTHI/MTLO or an ignored encoding).
    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        start   = 1'b1;
        op      = o;
        rs_data = v;
        @(negedge clk);
        start = 1'b0;
        if (o == OP_MTHI) m_hi = v;
        else if (o == OP_MTLO) m_lo = v;
        check($sformatf("mt_hilo_op%0d", o), {hi, lo}, {m_hi, m_lo});
        check("mt_busy", busy, 1'b0);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] x;
        logic [63:0] exp;
        logic        saw_done;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        rs_data = '0;
        rt_data = '0;
        mf_req  = 1'b0;
        flush   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hilo", {hi, lo}, 64'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_stall", stall, 1'b0);

        muldiv(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        check("mult_neg3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        muldiv(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        muldiv(OP_DIVU, 32'h0000_1234, 32'h0);
        check("divu_by0", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        muldiv(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        muldiv(OP_DIV, 32'h8000_0005, 32'h0);
        check("div_by0_neg", {hi, lo}, 64'h8000_0005_FFFF_FFFF);

        // mf_req and an MTLO held from T+5 must stall until T+34
        a = $urandom;
        b = $urandom;
        x = $urandom;
        exp = ref_model(OP_MULT, a, b);
        start   = 1'b1;
        op      = OP_MULT;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (k >= 5) begin
                mf_req  = 1'b1;
                start   = 1'b1;
                op      = OP_MTLO;
                rs_data = x;
            end
            #1;
            check($sformatf("stall_c%0d", k), stall, (k >= 5) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        #1;
        check("stall_t34", stall, 1'b0);
        check("stall_hilo_t34", {hi, lo}, exp);
        @(negedge clk);
        start  = 1'b0;
        mf_req = 1'b0;
        m_hi = exp[63:32];
        m_lo = x;
        check("mtlo_after_stall", {hi, lo}, {m_hi, m_lo});

        // flush in CALC
        mt(OP_MTHI, 32'h1111_1111);
        mt(OP_MTLO, 32'h2222_2222);
        saw_done = 1'b0;
        start   = 1'b1;
        op      = OP_DIV;
        rs_data = $urandom;
        rt_data = $urandom;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_hilo", {hi, lo}, 64'h1111_1111_2222_2222);
        for (int k = 0; k < 30; k++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        check("flush_no_done", saw_done, 1'b0);

        // flush wins over start in IDLE
        flush   = 1'b1;
        start   = 1'b1;
        op      = OP_DIVU;
        rs_data = $urandom;
        rt_data = $urandom;
        @(negedge clk);
        check("flush_start_busy", busy, 1'b0);
        op      = OP_MTHI;
        rs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_hilo", {hi, lo}, 64'h1111_1111_2222_2222);
        check("flush_start_busy2", busy, 1'b0);

        // reset in the middle of a MULTU
        saw_done = 1'b0;
        start   = 1'b1;
        op      = OP_MULTU;
        rs_data = $urandom;
        rt_data = $urandom;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 20; k++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        check("mid_rst_no_done", saw_done, 1'b0);
        mt(OP_MTHI, 32'hCAFE_BABE);
        check("mthi_cafe", hi, 32'hCAFE_BABE);

        for (int i = 0; i < 24; i++) begin
            r_op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if (r_op <= OP_DIVU) muldiv(r_op, a, b);
            else mt(r_op, a);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
